// File: rtl/nios_practica_sample_out_pkg.sv
// Shared constants for the audio sample output stage: register map and bit positions.
package nios_practica_sample_out_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_CONTROL  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_THRESH   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_LEVEL    = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_UNDERRUN = 3'd5;

    localparam int unsigned ST_LW       = 0;
    localparam int unsigned ST_EMPTY    = 1;
    localparam int unsigned ST_FULL     = 2;
    localparam int unsigned ST_UNDERRUN = 3;
    localparam int unsigned ST_OVERFLOW = 4;

    localparam int unsigned CTRL_IEN   = 0;
    localparam int unsigned CTRL_RUN   = 1;
    localparam int unsigned CTRL_FLUSH = 2;

endpackage

// File: rtl/nios_practica_sample_fifo.sv
// Sample FIFO with occupancy count; head word is presented combinationally.
module nios_practica_sample_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    // Pointers wrap naturally at DEPTH; level tracks the fill count separately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

endmodule

// File: rtl/nios_practica_sample_out.sv
// Avalon-MM audio sample output stage: CPU fills a FIFO, timer ticks pop samples out,
// low-water interrupt asks the ISR for a refill.
module nios_practica_sample_out #(
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter int unsigned THRESH_RESET = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    input  logic        sample_tick,
    output logic [15:0] sample_out,
    output logic        sample_valid
);
    import nios_practica_sample_out_pkg::*;

    localparam int unsigned LW = DEPTH_LOG2 + 1;

    logic              wr;
    logic              wr_status;
    logic              wr_ctrl;
    logic              wr_data;
    logic              wr_thresh;
    logic              wr_under;
    logic              flush;
    logic              pop;
    logic              push_ok;
    logic              overflow_set;
    logic              underrun_set;
    logic              lw;
    logic              lw_event;

    logic              fifo_empty;
    logic              fifo_full;
    logic [LW-1:0]     fifo_level;
    logic [DATA_W-1:0] fifo_head;

    logic              ctrl_ien;
    logic              ctrl_run;
    logic [LW-1:0]     thresh;
    logic              lw_d;
    logic              lw_occurred;
    logic              underrun_sticky;
    logic              overflow_sticky;
    logic [DATA_W-1:0] underrun_cnt;

    logic              lw_occurred_nxt;
    logic              underrun_nxt;
    logic              overflow_nxt;
    logic              ien_nxt;
    logic              run_nxt;
    logic [LW-1:0]     thresh_nxt;
    logic [DATA_W-1:0] underrun_cnt_nxt;
    logic [DATA_W-1:0] rd_mux;

    assign wr        = chipselect & ~write_n;
    assign wr_status = wr & (address == ADDR_STATUS);
    assign wr_ctrl   = wr & (address == ADDR_CONTROL);
    assign wr_data   = wr & (address == ADDR_DATA);
    assign wr_thresh = wr & (address == ADDR_THRESH);
    assign wr_under  = wr & (address == ADDR_UNDERRUN);

    // Empty is the pre-push view, so a word written on an empty tick is stored, not popped.
    assign flush        = wr_ctrl & writedata[CTRL_FLUSH];
    assign pop          = sample_tick & ctrl_run & ~fifo_empty & ~flush;
    assign push_ok      = wr_data & (~fifo_full | pop);
    assign overflow_set = wr_data & ~push_ok;
    assign underrun_set = sample_tick & ctrl_run & fifo_empty;
    assign lw           = (fifo_level <= thresh);
    assign lw_event     = lw & ~lw_d;

    nios_practica_sample_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_ok),
        .pop     (pop),
        .flush   (flush),
        .wdata   (writedata),
        .rdata   (fifo_head),
        .level   (fifo_level),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Register-file next state; a STATUS write beats any same-cycle sticky set.
    always_comb begin
        lw_occurred_nxt  = lw_occurred | lw_event;
        underrun_nxt     = underrun_sticky | underrun_set;
        overflow_nxt     = overflow_sticky | overflow_set;
        ien_nxt          = ctrl_ien;
        run_nxt          = ctrl_run;
        thresh_nxt       = thresh;
        underrun_cnt_nxt = underrun_cnt;
        if (wr_status) begin
            lw_occurred_nxt = 1'b0;
            underrun_nxt    = 1'b0;
            overflow_nxt    = 1'b0;
        end
        if (wr_ctrl) begin
            ien_nxt = writedata[CTRL_IEN];
            run_nxt = writedata[CTRL_RUN];
        end
        if (wr_thresh) thresh_nxt = writedata[LW-1:0];
        if (wr_under) begin
            underrun_cnt_nxt = '0;
        end else if (underrun_set && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt_nxt = underrun_cnt + DATA_W'(1);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_STATUS: begin
                rd_mux[ST_LW]       = lw_occurred;
                rd_mux[ST_EMPTY]    = fifo_empty;
                rd_mux[ST_FULL]     = fifo_full;
                rd_mux[ST_UNDERRUN] = underrun_sticky;
                rd_mux[ST_OVERFLOW] = overflow_sticky;
            end
            ADDR_CONTROL: begin
                rd_mux[CTRL_IEN] = ctrl_ien;
                rd_mux[CTRL_RUN] = ctrl_run;
            end
            ADDR_THRESH:   rd_mux[LW-1:0] = thresh;
            ADDR_LEVEL:    rd_mux[LW-1:0] = fifo_level;
            ADDR_UNDERRUN: rd_mux = underrun_cnt;
            default:       rd_mux = '0;
        endcase
    end

    // lw_d resets high so the empty-after-reset state is not seen as a crossing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_ien        <= 1'b0;
            ctrl_run        <= 1'b0;
            thresh          <= LW'(THRESH_RESET);
            lw_d            <= 1'b1;
            lw_occurred     <= 1'b0;
            underrun_sticky <= 1'b0;
            overflow_sticky <= 1'b0;
            underrun_cnt    <= '0;
            readdata        <= '0;
            sample_out      <= '0;
            sample_valid    <= 1'b0;
            irq             <= 1'b0;
        end else begin
            ctrl_ien        <= ien_nxt;
            ctrl_run        <= run_nxt;
            thresh          <= thresh_nxt;
            lw_d            <= lw;
            lw_occurred     <= lw_occurred_nxt;
            underrun_sticky <= underrun_nxt;
            overflow_sticky <= overflow_nxt;
            underrun_cnt    <= underrun_cnt_nxt;
            readdata        <= rd_mux;
            sample_valid    <= pop;
            if (pop) sample_out <= fifo_head;
            irq             <= lw_occurred_nxt & ien_nxt;
        end
    end

endmodule
